// File: rtl/im_resp.sv
// Instruction memory with a valid/ready fetch port, fixed read latency and a 2-credit response FIFO.
// Optional IM_RANGE_CHECK_EN turns misaligned or out-of-window fetches into error responses.
module im_resp #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE       = 32'h0000_3000,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  accept, consume, rd_err;

  assign req_idx   = DEPTH_LOG2'((req_addr - BASE) >> 2);
  assign consume   = rsp_valid && rsp_ready;
  assign req_ready = (state_q != FULL) || consume;
  assign accept    = req_valid && req_ready;

`ifdef IM_RANGE_CHECK_EN
  localparam logic [32:0] HI_LIM = {1'b0, BASE} + (33'd1 << (DEPTH_LOG2 + 2));
  assign rd_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || ({1'b0, req_addr} >= HI_LIM);
`else
  assign rd_err = 1'b0;
`endif

  // Credit state doubles as the outstanding count.
  always_comb begin
    state_d = state_q;
    if (accept && !consume)      state_d = state_t'(state_q + 2'd1);
    else if (consume && !accept) state_d = state_t'(state_q - 2'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Read-before-write array; a same-cycle load to the fetched index is forwarded via byp_*.
  logic [31:0] mem_rd_q;
  always_ff @(posedge clk) begin
    if (ld_en && !reset) mem[ld_addr] <= ld_data;
    mem_rd_q <= mem[req_idx];
  end

  logic        v0_d, e0_d, byp_d;
  logic        v0_q, e0_q, byp_q;
  logic [31:0] byp_data_d, byp_data_q;

  always_comb begin
    v0_d       = accept;
    e0_d       = rd_err;
    byp_d      = ld_en && (ld_addr == req_idx);
    byp_data_d = ld_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q       <= 1'b0;
      e0_q       <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      v0_q       <= v0_d;
      e0_q       <= e0_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  logic        chain_v [LATENCY];
  logic        chain_e [LATENCY];
  logic [31:0] chain_d [LATENCY];

  assign chain_v[0] = v0_q;
  assign chain_e[0] = e0_q;
  assign chain_d[0] = e0_q ? 32'h0 : (byp_q ? byp_data_q : mem_rd_q);

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    logic        v_q, e_q;
    logic [31:0] d_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        e_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= chain_v[gi-1];
        e_q <= chain_e[gi-1];
        d_q <= chain_d[gi-1];
      end
    end
    assign chain_v[gi] = v_q;
    assign chain_e[gi] = e_q;
    assign chain_d[gi] = d_q;
  end

  // Pipeline output bypasses an empty FIFO; anything not taken immediately is parked behind older entries.
  logic        out_v, out_e;
  logic [31:0] out_d;
  assign out_v = chain_v[LATENCY-1];
  assign out_e = chain_e[LATENCY-1];
  assign out_d = chain_d[LATENCY-1];

  logic [1:0][31:0] fifo_data_q, fifo_data_d;
  logic [1:0]       fifo_err_q, fifo_err_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             fifo_empty, push, pop;

  assign fifo_empty = (cnt_q == 2'd0);
  assign push       = out_v && !(fifo_empty && rsp_ready);
  assign pop        = !fifo_empty && rsp_ready;

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = out_d;
      fifo_err_d[wr_ptr_q]  = out_e;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_data_q <= '0;
      fifo_err_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_err_q  <= fifo_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = !fifo_empty || out_v;
  assign rsp_data  = !rsp_valid ? 32'h0 : (fifo_empty ? out_d : fifo_data_q[rd_ptr_q]);
  assign rsp_err   = rsp_valid && (fifo_empty ? out_e : fifo_err_q[rd_ptr_q]);
endmodule

// File: tb/tb_im_resp.sv
// Scoreboard bench for im_resp: expected words are queued at accept and compared at consume.
module tb_im_resp;
  localparam int          DL   = 12;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int          LAT  = 2;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en;
  logic [31:0]   req_addr, rsp_data, ld_data;
  logic [DL-1:0] ld_addr;

  always #5 clk = ~clk;

  im_resp #(.DEPTH_LOG2(DL), .BASE(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [1 << DL];
  int          checks = 0, failures = 0, cyc = 0;
  bit          chk_lat = 0, stall_prev = 0, acc_seen = 0;
  logic [31:0] stall_data;
  logic        stall_err;

  function automatic exp_t expect_for(logic [31:0] a);
    exp_t          e;
    logic [31:0]   off;
    logic [DL-1:0] idx;
    off    = (a - BASE) >> 2;
    idx    = off[DL-1:0];
    e.data = (ld_en && ld_addr == idx) ? ld_data : mdl[idx];
    e.err  = 1'b0;
    e.acc  = cyc;
`ifdef IM_RANGE_CHECK_EN
    if (a[1:0] != 2'b00 || a < BASE || {1'b0, a} >= ({1'b0, BASE} + (33'd1 << (DL + 2)))) begin
      e.err  = 1'b1;
      e.data = 32'h0;
    end
`endif
    return e;
  endfunction

  // One clock: sample handshakes at negedge, then return 1ns after the next posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc_seen = req_valid && req_ready;
    if (stall_prev) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== stall_data || rsp_err !== stall_err) begin
        failures++;
        $display("FAIL hold: valid=%b data=%h err=%b required valid=1 data=%h err=%b",
                 rsp_valid, rsp_data, rsp_err, stall_data, stall_err);
      end
    end
    stall_prev = rsp_valid && !rsp_ready;
    stall_data = rsp_data;
    stall_err  = rsp_err;
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: data=%h err=%b required no response", rsp_data, rsp_err);
      end else begin
        e = sb.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err) begin
          failures++;
          $display("FAIL rsp: data=%h err=%b required data=%h err=%b", rsp_data, rsp_err, e.data, e.err);
        end else begin
          $display("RSP data=%h err=%b cycle=%0d", rsp_data, rsp_err, cyc);
        end
        if (chk_lat) begin
          checks++;
          if (cyc - e.acc != LAT) begin
            failures++;
            $display("FAIL latency: got %0d cycles required %0d", cyc - e.acc, LAT);
          end
        end
      end
    end
    if (acc_seen) begin
      e = expect_for(req_addr);
      sb.push_back(e);
      $display("REQ addr=%h expect data=%h err=%b cycle=%0d", req_addr, e.data, e.err, cyc);
    end
    if (ld_en) mdl[ld_addr] = ld_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input logic [DL-1:0] idx, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = idx; ld_data = d;
    cycle();
    ld_en = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() > 0; k++) cycle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h err=%b required 0/0/0", rsp_valid, rsp_data, rsp_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
    cycle();
  endtask

  task automatic test_basic();
    load('0, 32'h3c01_0000);
    rsp_ready = 1'b0; req_addr = 32'h0000_3000; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    checks++;
    if (!acc_seen) begin
      failures++;
      $display("FAIL basic_accept: accepted=0 required 1");
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early: rsp_valid=%b one cycle after accept required 0", rsp_valid);
    end
    cycle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h3c01_0000 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_lat2: valid=%b data=%h err=%b required 1/3c010000/0", rsp_valid, rsp_data, rsp_err);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] a [3];
    int n;
    a[0] = 32'h3000; a[1] = 32'h3004; a[2] = 32'h3008;
    n = 0;
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 6 && n < 2; k++) begin
      req_addr = a[n];
      cycle();
      if (acc_seen) n++;
    end
    req_addr = a[2];
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: req_ready=%b with two outstanding required 0", req_ready);
    end
    cycle();
    cycle();
    checks++;
    if (acc_seen) begin
      failures++;
      $display("FAIL bp_third: third request accepted while full required held off");
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: req_ready=%b with consume required 1", req_ready);
    end
    cycle();
    checks++;
    if (!acc_seen) begin
      failures++;
      $display("FAIL bp_same_cycle: third accepted=0 required 1");
    end
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1; chk_lat = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_addr = BASE + 32'(4 * k); req_valid = 1'b1;
      cycle();
      checks++;
      if (!acc_seen) begin
        failures++;
        $display("FAIL b2b_accept: request %0d accepted=0 required 1", k);
      end
    end
    req_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
  endtask

  task automatic test_load_bypass();
    rsp_ready = 1'b1;
    ld_en = 1'b1; ld_addr = 12'd5; ld_data = 32'hdead_beef;
    req_addr = 32'h0000_3014; req_valid = 1'b1;
    cycle();
    ld_en = 1'b0;
    req_addr = 32'h0000_3018;
    cycle();
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 12'd6; ld_data = 32'h0bad_0006;
    cycle();
    ld_en = 1'b0;
    drain();
  endtask

  task automatic test_range();
    logic [31:0] a [4];
    a[0] = 32'h0000_2ffc; a[1] = 32'h0000_3002; a[2] = 32'h0000_7000; a[3] = 32'h0000_6ffc;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = a[k]; req_valid = 1'b1;
      cycle();
    end
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0; req_addr = 32'h0000_3004; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    reset = 1'b1;
    ld_en = 1'b1; ld_addr = '0; ld_data = 32'hffff_ffff;
    #2;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_valid: rsp_valid=%b during reset required 0", rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    ld_en = 1'b0;
    reset = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_ready: req_ready=%b after release required 1", req_ready);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_ghost: rsp_valid=%b %0d cycles after release required 0", rsp_valid, k + 1);
      end
    end
    req_addr = 32'h0000_3000; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 8; i++) load(DL'(i), 32'h1000_0000 + 32'(i * 32'h0101));
    load({DL{1'b1}}, 32'hfeed_f00d);
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_load_bypass();
    test_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/im_resp.md
IM_RESP -- requirements
Module: im_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 12: memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter BASE, default 32'h00003000: byte address of word 0.
REQ-003 Parameter LATENCY, default 2, legal 1..4: cycles from request accept to response presentation.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_addr  input  32  byte address of the requested instruction.
REQ-009 rsp_valid  output  1  response word available.
REQ-010 rsp_ready  input  1  requester consumes the response this cycle.
REQ-011 rsp_data  output  32  instruction word.
REQ-012 rsp_err  output  1  response is an address fault.
REQ-013 ld_en  input  1  program-load write strobe.
REQ-014 ld_addr  input  DEPTH_LOG2  word index for the load write.
REQ-015 ld_data  input  32  word to write.

Function
REQ-016 Accept occurs on a cycle with req_valid && req_ready; memory is read in that cycle, index = (req_addr - BASE) >> 2, truncated to DEPTH_LOG2 bits.
REQ-017 Accepted data enters a LATENCY-stage pipeline, then a 2-entry in-order response FIFO; first accepted response reaches rsp_valid exactly LATENCY cycles after accept when the FIFO is empty.
REQ-018 Credit counter outstanding (0..2) counts accepted-but-unconsumed requests: +1 on accept, -1 on rsp_valid && rsp_ready, net 0 when both occur in one cycle.
REQ-019 req_ready = (outstanding < 2) || (outstanding == 2 && rsp_valid && rsp_ready); requests are never dropped.
REQ-020 rsp_valid, rsp_data, rsp_err hold stable while rsp_valid && !rsp_ready.
REQ-021 Responses return in accept order; back-to-back accepts with rsp_ready held high sustain one response per cycle.
REQ-022 Load write updates memory at posedge when ld_en; a fetch accepted in the same cycle at the same index returns ld_data (write-first).
REQ-023 A load to an index after its fetch was accepted does not alter that in-flight response.
REQ-024 Derived state: IDLE (outstanding 0), BUSY (1), FULL (2); transitions only per REQ-018.

Reset
REQ-025 On reset assertion, immediately: outstanding=0, pipeline and FIFO emptied, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1 after release.
REQ-026 Reset mid-operation discards all in-flight requests; no response for them appears after release.
REQ-027 Memory contents are not cleared by reset; ld_en is ignored while reset is high.

Configuration
REQ-028 Macro IM_RANGE_CHECK_EN defined: request with req_addr[1:0] != 0, req_addr < BASE, or req_addr >= BASE + 4*2^DEPTH_LOG2 is still accepted and consumes a credit but responds with rsp_err=1, rsp_data=0.
REQ-029 IM_RANGE_CHECK_EN undefined: no checking, index truncated per REQ-016, rsp_err tied 0.

Verification
REQ-030 Reset, load word 0 = 32'h3c010000, request 32'h00003000 -> rsp_valid with 32'h3c010000, rsp_err=0, exactly 2 cycles after accept.
REQ-031 rsp_ready held 0, three consecutive requests -> two accepted, req_ready=0 on third; raise rsp_ready -> third accepted same cycle first response consumed, responses in order.
REQ-032 rsp_ready=1, requests at 32'h3000/3004/3008 on successive cycles -> one response per cycle, no bubbles after initial 2-cycle latency.
REQ-033 ld_en to index 5 with 32'hdeadbeef same cycle as request 32'h00003014 -> rsp_data=32'hdeadbeef.
REQ-034 With IM_RANGE_CHECK_EN: request 32'h00002ffc and 32'h00003002 -> rsp_err=1, rsp_data=0; without macro, rsp_err=0.
REQ-035 Assert reset one cycle after an accept -> rsp_valid stays 0 through and after release; outstanding returns to 0.
